// File: rtl/keypad_pin_collector_if.sv
// rtl/keypad_pin_collector_if.sv - keypad PIN collector port bundle towards the access controller
interface keypad_pin_collector_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int PIN_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic             sensor_llegada_vehiculo;
    logic             tecla_valida;
    logic [3:0]       tecla_codigo;
    logic             clave_ack;
    logic [PIN_W-1:0] clave_ingresada;
    logic             clave_valida;
    logic [CNT_W-1:0] digitos_ingresados;
    logic             error_timeout;

    modport master (
        input  sensor_llegada_vehiculo,
        input  tecla_valida,
        input  tecla_codigo,
        input  clave_ack,
        output clave_ingresada,
        output clave_valida,
        output digitos_ingresados,
        output error_timeout
    );

    modport slave (
        output sensor_llegada_vehiculo,
        output tecla_valida,
        output tecla_codigo,
        output clave_ack,
        input  clave_ingresada,
        input  clave_valida,
        input  digitos_ingresados,
        input  error_timeout
    );
endinterface

// File: rtl/keypad_pin_collector.sv
// rtl/keypad_pin_collector.sv - collects keypad digits into a BCD PIN and hands it off with valid/ack
module keypad_pin_collector #(
    parameter int NUM_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    keypad_pin_collector_if.master         pin_if
);
    localparam int PIN_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(NUM_DIGITS);
    localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         KEY_CLEAR = 4'hA;
    localparam logic [3:0]         KEY_ENTER = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURA,
        S_ENTREGA
    } state_t;

    state_t             state_q, state_d;
    logic [PIN_W-1:0]   buffer_q, buffer_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               valida_q, valida_d;
    logic               error_q, error_d;

    logic sensor, key, ack;
    logic [3:0] code;

    assign sensor = pin_if.sensor_llegada_vehiculo;
    assign key    = pin_if.tecla_valida;
    assign code   = pin_if.tecla_codigo;
    assign ack    = pin_if.clave_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            buffer_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            valida_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            buffer_q <= buffer_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            valida_q <= valida_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        buffer_d = buffer_q;
        count_d  = count_q;
        timer_d  = timer_q;
        valida_d = 1'b0;
        error_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sensor) begin
                    state_d  = S_CAPTURA;
                    buffer_d = '0;
                    count_d  = '0;
                    timer_d  = '0;
                end
            end

            S_CAPTURA: begin
                if (!sensor) begin
                    state_d  = S_IDLE;
                    buffer_d = '0;
                    count_d  = '0;
                    timer_d  = '0;
                end else if (key) begin
                    // Any strobe, even an ignored one, holds the inactivity timer.
                    if (code <= 4'd9) begin
                        if (count_q < CNT_FULL) begin
                            buffer_d = {buffer_q[PIN_W-5:0], code};
                            count_d  = count_q + CNT_W'(1);
                            timer_d  = '0;
                        end
                    end else if (code == KEY_CLEAR) begin
                        buffer_d = '0;
                        count_d  = '0;
                        timer_d  = '0;
                    end else if (code == KEY_ENTER && count_q == CNT_FULL) begin
                        state_d  = S_ENTREGA;
                        valida_d = 1'b1;
                    end
                end else if (count_q != '0) begin
                    if (timer_q == TIMER_END) begin
                        buffer_d = '0;
                        count_d  = '0;
                        timer_d  = '0;
                        error_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end

            S_ENTREGA: begin
                valida_d = 1'b1;
                if (!sensor || ack) begin
                    state_d  = (sensor && ack) ? S_CAPTURA : S_IDLE;
                    buffer_d = '0;
                    count_d  = '0;
                    timer_d  = '0;
                    valida_d = 1'b0;
                end
            end

            default: begin
                state_d  = S_IDLE;
                buffer_d = '0;
                count_d  = '0;
                timer_d  = '0;
            end
        endcase
    end

    assign pin_if.clave_ingresada    = buffer_q;
    assign pin_if.clave_valida       = valida_q;
    assign pin_if.digitos_ingresados = count_q;
    assign pin_if.error_timeout      = error_q;
endmodule

// File: tb/tb_keypad_pin_collector.sv
// tb/tb_keypad_pin_collector.sv - scoreboard bench for keypad_pin_collector with a queue-based PIN model
module tb_keypad_pin_collector;
    localparam int ND = 4;
    localparam int TO = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    keypad_pin_collector_if #(.NUM_DIGITS(ND)) pif ();

    keypad_pin_collector #(
        .NUM_DIGITS    (ND),
        .TIMEOUT_CYCLES(TO),
        .TIMER_W       (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pin_if(pif)
    );

    typedef struct {
        logic [15:0] pin;
        logic        valida;
        logic [2:0]  cnt;
        logic        err;
    } snap_t;

    snap_t       snap_q[$];
    logic [15:0] pin_q[$];
    bit          mon_en = 1'b0;
    logic        prev_v = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 collecting, 2 PIN on offer.
    int m_phase = 0;
    int m_digits[$];
    int m_idle = 0;
    bit m_err = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack_pin();
        logic [15:0] p;
        p = '0;
        foreach (m_digits[i]) p = {p[11:0], 4'(m_digits[i])};
        return p;
    endfunction

    task automatic model_step(bit s, bit kv, logic [3:0] code, bit ack);
        m_err = 1'b0;
        case (m_phase)
            0: if (s) begin m_phase = 1; m_digits.delete(); m_idle = 0; end
            1: begin
                if (!s) begin
                    m_phase = 0; m_digits.delete(); m_idle = 0;
                end else if (kv) begin
                    if (code <= 4'd9) begin
                        if (m_digits.size() < ND) begin m_digits.push_back(int'(code)); m_idle = 0; end
                    end else if (code == 4'hA) begin
                        m_digits.delete(); m_idle = 0;
                    end else if (code == 4'hB && m_digits.size() == ND) begin
                        m_phase = 2;
                        pin_q.push_back(pack_pin());
                    end
                end else if (m_digits.size() > 0) begin
                    m_idle++;
                    if (m_idle == TO) begin m_digits.delete(); m_idle = 0; m_err = 1'b1; end
                end
            end
            default: if (!s || ack) begin
                m_phase = (s && ack) ? 1 : 0;
                m_digits.delete(); m_idle = 0;
            end
        endcase
        snap_q.push_back('{pack_pin(), (m_phase == 2), 3'(m_digits.size()), m_err});
    endtask

    task automatic step(bit s, bit kv, logic [3:0] code, bit ack);
        @(negedge clock);
        pif.sensor_llegada_vehiculo = s;
        pif.tecla_valida            = kv;
        pif.tecla_codigo            = code;
        pif.clave_ack               = ack;
        model_step(s, kv, code, ack);
    endtask

    task automatic key(logic [3:0] code);
        step(1'b1, 1'b1, code, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b1, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_pin"},    32'(pif.clave_ingresada),    32'h0);
        check({tag, "_valida"}, 32'(pif.clave_valida),       32'h0);
        check({tag, "_count"},  32'(pif.digitos_ingresados), 32'h0);
        check({tag, "_err"},    32'(pif.error_timeout),      32'h0);
    endtask

    initial begin
        snap_t e;
        forever begin
            @(posedge clock);
            #1;
            if (mon_en && snap_q.size() > 0) begin
                e = snap_q.pop_front();
                check("pin",    32'(pif.clave_ingresada),    32'(e.pin));
                check("valida", 32'(pif.clave_valida),       32'(e.valida));
                check("count",  32'(pif.digitos_ingresados), 32'(e.cnt));
                check("err",    32'(pif.error_timeout),      32'(e.err));
                if (pif.clave_valida && !prev_v) begin
                    if (pin_q.size() == 0) check("deliver_unexpected", 32'(pif.clave_valida), 32'h0);
                    else check("deliver_pin", 32'(pif.clave_ingresada), 32'(pin_q.pop_front()));
                end
            end
            prev_v = pif.clave_valida;
        end
    end

    initial begin
        int r;
        pif.sensor_llegada_vehiculo = 1'b0;
        pif.tecla_valida            = 1'b0;
        pif.tecla_codigo            = 4'h0;
        pif.clave_ack               = 1'b0;
        #1 reset = 1'b1;
        #1 check_zero("reset");
        repeat (2) @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;

        // T1: full PIN, held without ack, then ack
        idle(1);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hB);
        idle(5);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        idle(1);
        // T2: early enter ignored
        key(4'h5); key(4'h6); key(4'h7); key(4'hB); idle(1);
        key(4'h8); key(4'hB); idle(2);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        // T3: fifth digit ignored, then clear
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'h9); key(4'hA); idle(1);
        // T4: timeout and key-in-expiry-cycle
        key(4'h3); idle(TO); idle(2);
        key(4'h3); idle(TO - 1); key(4'h5); idle(TO); idle(1);
        key(4'hC); key(4'hF);
        // T5: sensor drops while collecting and while offering
        key(4'h1); key(4'h2);
        step(1'b0, 1'b0, 4'h0, 1'b0); step(1'b0, 1'b1, 4'h3, 1'b0);
        idle(1);
        key(4'h1); key(4'h2); key(4'h3); key(4'h4); key(4'hB); idle(1);
        step(1'b0, 1'b0, 4'h0, 1'b0); step(1'b0, 1'b0, 4'h0, 1'b1);
        idle(1);
        key(4'h4); key(4'h3); key(4'h2); key(4'h1); key(4'hB);
        step(1'b0, 1'b0, 4'h0, 1'b1);
        step(1'b1, 1'b0, 4'h0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit s, kv, ack;
            logic [3:0] code;
            s   = ($urandom_range(0, 99) < 97);
            kv  = ($urandom_range(0, 99) < 35);
            ack = ($urandom_range(0, 99) < 30);
            r   = int'($urandom_range(0, 19));
            if (r < 10)      code = 4'(r);
            else if (r < 15) code = 4'hB;
            else if (r < 17) code = 4'hA;
            else             code = 4'($urandom_range(12, 15));
            step(s, kv, code, ack);
        end

        // T6: asynchronous reset while a PIN is on offer
        step(1'b0, 1'b0, 4'h0, 1'b0);
        idle(1);
        key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'hB); idle(2);
        @(posedge clock);
        #3;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1 check_zero("async_reset");
        pif.sensor_llegada_vehiculo = 1'b0;
        pif.tecla_valida            = 1'b0;
        pif.clave_ack               = 1'b0;
        repeat (2) @(negedge clock);
        check_zero("reset_hold");
        reset = 1'b0;
        m_phase = 0; m_digits.delete(); m_idle = 0;
        snap_q.delete(); pin_q.delete();
        mon_en = 1'b1;
        idle(1);
        key(4'h4); key(4'h3); key(4'h2); key(4'h1); key(4'hB); idle(2);
        step(1'b1, 1'b0, 4'h0, 1'b1);
        idle(2);

        @(posedge clock);
        #2;
        check("drain", 32'(snap_q.size() + pin_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
